// File: rtl/inflight_filter_tracker_if.sv
// Bundle between the in-flight tracker and its environment: request/retire stream,
// counting bloom filter ports and occupancy status.
interface inflight_filter_tracker_if #(
    parameter int InpWidth = 11,
    parameter int CntWidth = 4
);
    logic                flush_i;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [InpWidth-1:0] req_data_i;
    logic                ret_valid_i;
    logic                ret_ready_o;
    logic [InpWidth-1:0] ret_data_o;
    logic [InpWidth-1:0] look_data_o;
    logic                look_valid_i;
    logic [InpWidth-1:0] incr_data_o;
    logic                incr_valid_o;
    logic [InpWidth-1:0] decr_data_o;
    logic                decr_valid_o;
    logic                filter_clear_o;
    logic                filter_full_i;
    logic [CntWidth-1:0] inflight_o;
    logic                empty_o;
    logic                full_o;
    logic                err_o;

    // The tracker is the slave; the master is the upstream stream plus the filter.
    modport slave (
        input  flush_i, req_valid_i, req_data_i, ret_valid_i, look_valid_i, filter_full_i,
        output req_ready_o, ret_ready_o, ret_data_o, look_data_o, incr_data_o, incr_valid_o,
               decr_data_o, decr_valid_o, filter_clear_o, inflight_o, empty_o, full_o, err_o
    );

    modport master (
        output flush_i, req_valid_i, req_data_i, ret_valid_i, look_valid_i, filter_full_i,
        input  req_ready_o, ret_ready_o, ret_data_o, look_data_o, incr_data_o, incr_valid_o,
               decr_data_o, decr_valid_o, filter_clear_o, inflight_o, empty_o, full_o, err_o
    );
endinterface

// File: rtl/inflight_filter_tracker.sv
// Initiator-side controller for a counting bloom filter: inserts accepted requests,
// keeps them in an in-order FIFO, removes them on retire and stalls likely hazards.
module inflight_filter_tracker #(
    parameter int  InpWidth = 11,
    parameter int  Depth    = 8,
    localparam int CntWidth = $clog2(Depth + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    inflight_filter_tracker_if.slave bus
);
    localparam int PtrWidth = $clog2(Depth);

    typedef enum logic {
        RUN,
        CLEAR
    } state_t;

    state_t              state;
    logic                armed;
    logic                err;
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;
    logic [InpWidth-1:0] mem [Depth];

    logic running;
    logic empty;
    logic full;
    logic req_fire;
    logic ret_fire;

    // armed keeps both handshakes closed until the first clock after reset release.
    assign running  = armed && (state == RUN);
    assign empty    = (count == '0);
    assign full     = (count == CntWidth'(Depth));
    assign req_fire = bus.req_valid_i && bus.req_ready_o;
    assign ret_fire = bus.ret_valid_i && bus.ret_ready_o;

    assign bus.req_ready_o    = running && !full && !bus.filter_full_i &&
                                !bus.look_valid_i && !bus.flush_i;
    assign bus.ret_ready_o    = running && !empty && !bus.flush_i;
    assign bus.incr_valid_o   = req_fire;
    assign bus.incr_data_o    = req_fire ? bus.req_data_i : '0;
    assign bus.decr_valid_o   = ret_fire;
    assign bus.decr_data_o    = ret_fire ? mem[rd_ptr] : '0;
    assign bus.ret_data_o     = empty ? '0 : mem[rd_ptr];
    assign bus.look_data_o    = bus.req_data_i;
    assign bus.filter_clear_o = (state == CLEAR);
    assign bus.inflight_o     = count;
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.err_o          = err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
            armed <= 1'b0;
            err   <= 1'b0;
        end else begin
            armed <= 1'b1;
            err   <= (state == RUN) && bus.ret_valid_i && empty;
            case (state)
                RUN:     if (bus.flush_i) state <= CLEAR;
                CLEAR:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if ((state == RUN) && bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (req_fire) wr_ptr <= wr_ptr + 1'b1;
            if (ret_fire) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CntWidth'(req_fire) - CntWidth'(ret_fire);
        end
    end

    // Storage needs no reset: reads are masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (req_fire) mem[wr_ptr] <= bus.req_data_i;
    end
endmodule

// File: doc/inflight_filter_tracker.md
Name: inflight_filter_tracker

Overview:
- Initiator-side controller for the counting bloom filter (`cb_filter`) interface. It drives the filter's increment, decrement, lookup and clear ports from a request/retire stream.
- Accepted requests are inserted into the filter and pushed into an in-order FIFO. Retires pop the FIFO head and remove that item from the filter.
- A new request whose data may already be in flight (filter lookup positive) is stalled. This gives conservative hazard serialisation for outstanding transactions, e.g. address tracking in front of a memory port.

Parameters:
- InpWidth, 11, width of tracked data item; must equal the filter's InpWidth.
- Depth, 8, maximum outstanding items; power of two, >= 2.
- CntWidth, $clog2(Depth+1), width of the occupancy counter (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  single-cycle request: discard all outstanding items and clear the filter
- req_valid_i  in  1  new item valid
- req_ready_o  out  1  new item accepted when valid&ready
- req_data_i  in  InpWidth  new item
- ret_valid_i  in  1  retire oldest outstanding item
- ret_ready_o  out  1  retire accepted when valid&ready
- ret_data_o  out  InpWidth  oldest outstanding item (FIFO head)
- look_data_o  out  InpWidth  to filter look_data_i; equals req_data_i
- look_valid_i  in  1  from filter look_valid_o
- incr_data_o  out  InpWidth  to filter incr_data_i
- incr_valid_o  out  1  to filter incr_valid_i
- decr_data_o  out  InpWidth  to filter decr_data_i
- decr_valid_o  out  1  to filter decr_valid_i
- filter_clear_o  out  1  to filter filter_clear_i
- filter_full_i  in  1  from filter filter_full_o
- inflight_o  out  CntWidth  number of outstanding items
- empty_o  out  1  inflight_o == 0
- full_o  out  1  inflight_o == Depth
- err_o  out  1  one-cycle pulse: ret_valid_i while empty

Behaviour:
- Reset (async, rst_ni low):
  - FSM = RUN; FIFO pointers and count = 0.
  - Outputs: req_ready_o=0, ret_ready_o=0, incr_valid_o=0, decr_valid_o=0, filter_clear_o=0, err_o=0, inflight_o=0, empty_o=1, full_o=0.
  - ret_data_o, incr_data_o and decr_data_o are 0 while empty/idle.
- FSM states:
  - RUN: normal operation.
  - CLEAR: exactly one cycle. filter_clear_o=1, req_ready_o=0, ret_ready_o=0, incr_valid_o=0, decr_valid_o=0.
- Transitions:
  - RUN --flush_i--> CLEAR.
  - CLEAR --> RUN unconditionally.
  - flush_i in CLEAR is ignored.
- Flush:
  - The FIFO count and pointers are zeroed at the RUN->CLEAR edge.
  - In the flush cycle itself (RUN, flush_i=1), req_ready_o and ret_ready_o are forced 0. No handshake completes in that cycle.
- Request path (RUN only):
  - req_ready_o = !full_o & !filter_full_i & !look_valid_i & !flush_i.
  - On req handshake: incr_valid_o=1 and incr_data_o=req_data_i in the same cycle (combinational); item written to FIFO tail.
  - Filter insertion is visible to lookups from the next cycle.
  - Items are never dropped: the upstream holds req_valid_i/req_data_i until ready.
- Retire path (RUN only):
  - ret_ready_o = !empty_o & !flush_i.
  - On retire handshake: decr_valid_o=1 and decr_data_o=FIFO head in the same cycle; head popped.
  - ret_data_o always shows the head when non-empty.
- Simultaneous req and retire handshakes:
  - Both complete; count unchanged.
  - Valid when full: the retire frees the slot only next cycle, so req_ready_o stays 0 when full.
  - A request equal to the retiring head stalls that cycle (look_valid_i still 1) and is accepted the next cycle.
- Error:
  - ret_valid_i=1 in RUN with empty_o=1 gives err_o=1 for one cycle (registered, appears the next cycle).
  - The retire is ignored; nothing else changes.
- Counter and status:
  - inflight_o is registered and exact; no wrap.
  - Pointers are $clog2(Depth) bits and wrap naturally.
  - empty_o and full_o are derived from inflight_o.
- Lookup: look_data_o is combinationally tied to req_data_i at all times.

Test Plan:
- Reset, then push 3, 17, 42 with no retires -> incr_valid_o pulses 3 cycles with those data; inflight_o=3; ret_data_o=3.
- Retire 3 times -> decr_data_o 3, 17, 42 in order; empty_o=1 afterwards; a 4th ret_valid_i gives err_o=1 for one cycle and inflight_o stays 0.
- Push 8 distinct items (Depth=8) -> full_o=1 and req_ready_o=0. Then a simultaneous retire and req -> retire completes, req accepted the next cycle, inflight_o=8.
- Push 100, then req 100 again while outstanding -> req_ready_o=0 (look_valid_i=1) until 100 retires. On the retire cycle the req still stalls; it is accepted the following cycle.
- Push 5 items, pulse flush_i -> next cycle filter_clear_o=1 for exactly 1 cycle with no handshakes; then inflight_o=0, empty_o=1, and the filter reports empty.
- Random req/retire traffic with a connected filter for 100k cycles -> FIFO order matches the scoreboard, no filter_error, and inflight_o equals the scoreboard size each cycle.
